// File: rtl/avalon_arbiter_rr.sv
// rtl/avalon_arbiter_rr.sv - N-master Avalon-MM arbiter: round-robin grants, write-burst hold, read routing FIFO
// Define AVALON_ARBITER_FIXED_PRIORITY_EN to make the lowest-index requester always win.
module avalon_arbiter_rr #(
  parameter int Width         = 32,
  parameter int AddressWidth  = 32,
  parameter int Masters       = 4,
  parameter int ResponseDepth = 8
) (
  input  logic                             ipClk,
  input  logic                             ipReset,
  output logic [Masters-1:0]               opMaster_WaitRequest,
  input  logic [Masters*AddressWidth-1:0]  ipMaster_Address,
  input  logic [Masters*Width/8-1:0]       ipMaster_ByteEnable,
  input  logic [Masters*8-1:0]             ipMaster_BurstCount,
  input  logic [Masters*Width-1:0]         ipMaster_WriteData,
  input  logic [Masters-1:0]               ipMaster_Write,
  input  logic [Masters-1:0]               ipMaster_Read,
  output logic [Width-1:0]                 opMaster_ReadData,
  output logic [Masters-1:0]               opMaster_ReadValid,
  input  logic                             ipAvalon_WaitRequest,
  output logic [AddressWidth-1:0]          opAvalon_Address,
  output logic [Width/8-1:0]               opAvalon_ByteEnable,
  output logic [7:0]                       opAvalon_BurstCount,
  output logic [Width-1:0]                 opAvalon_WriteData,
  output logic                             opAvalon_Write,
  output logic                             opAvalon_Read,
  input  logic [Width-1:0]                 ipAvalon_ReadData,
  input  logic                             ipAvalon_ReadValid,
  output logic                             opError
);
  localparam int GW = $clog2(Masters);
  localparam int PW = $clog2(ResponseDepth);
  localparam int BW = Width / 8;

  typedef enum logic [1:0] {IDLE, GRANT, WBURST} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d;
  logic [7:0]    wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [Masters-1:0] req;
  logic [GW-1:0] pick;
  logic          found;
`ifndef AVALON_ARBITER_FIXED_PRIORITY_EN
  logic [GW:0]   cand;
`endif

  logic [GW-1:0] fid_q  [ResponseDepth];
  logic [7:0]    flen_q [ResponseDepth];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  logic [7:0]    hbeat_q;
  logic          err_q;
  logic          fifo_empty, fifo_full, push, pop, can_push;
  logic [7:0]    g_bc, g_len;
  logic          g_wr, g_rd;

  assign req = ipMaster_Read | ipMaster_Write;

  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef AVALON_ARBITER_FIXED_PRIORITY_EN
    for (int k = Masters - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick  = GW'(k);
        found = 1'b1;
      end
    end
`else
    cand = '0;
    // Walk the ring starting just after the previous winner.
    for (int k = 1; k <= Masters; k++) begin
      cand = {1'b0, last_q} + (GW+1)'(k);
      if (int'(cand) >= Masters) cand = cand - (GW+1)'(Masters);
      if (!found && req[cand[GW-1:0]]) begin
        pick  = cand[GW-1:0];
        found = 1'b1;
      end
    end
`endif
  end

  assign g_bc  = ipMaster_BurstCount[grant_q*8 +: 8];
  assign g_len = (g_bc == 8'd0) ? 8'd1 : g_bc;
  assign g_wr  = ipMaster_Write[grant_q];
  assign g_rd  = ipMaster_Read[grant_q];

  assign opAvalon_Address    = ipMaster_Address[grant_q*AddressWidth +: AddressWidth];
  assign opAvalon_ByteEnable = ipMaster_ByteEnable[grant_q*BW +: BW];
  assign opAvalon_BurstCount = g_bc;
  assign opAvalon_WriteData  = ipMaster_WriteData[grant_q*Width +: Width];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(ResponseDepth));
  assign pop        = ipAvalon_ReadValid && !fifo_empty && (hbeat_q + 8'd1 == flen_q[rd_q]);
  // A full FIFO can still take a new read in the cycle its head retires.
  assign can_push   = !fifo_full || pop;

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    last_d               = last_q;
    wlen_d               = wlen_q;
    wbeat_d              = wbeat_q;
    opMaster_WaitRequest = '1;
    opAvalon_Write       = 1'b0;
    opAvalon_Read        = 1'b0;
    push                 = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (g_wr) begin
          opAvalon_Write                = 1'b1;
          opMaster_WaitRequest[grant_q] = ipAvalon_WaitRequest;
          if (!ipAvalon_WaitRequest) begin
            if (g_len == 8'd1) begin
              state_d = IDLE;
            end else begin
              wlen_d  = g_len;
              wbeat_d = 8'd1;
              state_d = WBURST;
            end
          end
        end else if (g_rd) begin
          opAvalon_Read                 = can_push;
          opMaster_WaitRequest[grant_q] = ipAvalon_WaitRequest | !can_push;
          if (can_push && !ipAvalon_WaitRequest) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        opAvalon_Write                = g_wr;
        opMaster_WaitRequest[grant_q] = ipAvalon_WaitRequest;
        if (g_wr && !ipAvalon_WaitRequest) begin
          wbeat_d = wbeat_q + 8'd1;
          if (wbeat_q + 8'd1 == wlen_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign opMaster_ReadData = ipAvalon_ReadData;

  always_comb begin
    opMaster_ReadValid = '0;
    if (ipAvalon_ReadValid && !fifo_empty) opMaster_ReadValid[fid_q[rd_q]] = 1'b1;
  end

  always_ff @(posedge ipClk) begin
    if (push) begin
      fid_q[wr_q]  <= grant_q;
      flen_q[wr_q] <= g_len;
    end
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(Masters - 1);
      wlen_q  <= '0;
      wbeat_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      hbeat_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wlen_q  <= wlen_d;
      wbeat_q <= wbeat_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) begin
        rd_q    <= rd_q + PW'(1);
        hbeat_q <= '0;
      end else if (ipAvalon_ReadValid && !fifo_empty) begin
        hbeat_q <= hbeat_q + 8'd1;
      end
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
      if (ipAvalon_ReadValid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign opError = err_q;
endmodule

// File: doc/avalon_arbiter_rr.md
Name: avalon_arbiter_rr

Overview:
Parametrised N-master Avalon-MM arbiter with burst support, the successor to the two-master arbiter. It sits between several bus masters (DMA engines, CPU bridge) and one Avalon slave port such as the SDRAM controller. It grants masters round-robin and holds the grant for whole write bursts. Outstanding read bursts are tracked in a response FIFO, so each ReadValid beat goes back to the master that issued the read.

Parameters:
Width, 32, data width in bits; multiple of 8.
AddressWidth, 32, address width in bits.
Masters, 4, number of master ports; 2..16.
ResponseDepth, 8, max outstanding read commands; power of 2, >=2.

Ports:
ipClk  in  1  clock
ipReset  in  1  asynchronous reset, active-high
opMaster_WaitRequest  out  Masters  per-master wait request
ipMaster_Address  in  Masters*AddressWidth  master i at [i*AddressWidth +: AddressWidth]
ipMaster_ByteEnable  in  Masters*Width/8  packed per master
ipMaster_BurstCount  in  Masters*8  packed per master
ipMaster_WriteData  in  Masters*Width  packed per master
ipMaster_Write  in  Masters  per-master write strobe
ipMaster_Read  in  Masters  per-master read strobe
opMaster_ReadData  out  Width  shared read data; qualify with ReadValid
opMaster_ReadValid  out  Masters  one-hot read-data valid
ipAvalon_WaitRequest  in  1  slave wait request
opAvalon_Address / opAvalon_ByteEnable / opAvalon_BurstCount / opAvalon_WriteData  out  AddressWidth / Width/8 / 8 / Width  muxed from the granted master
opAvalon_Write  out  1  slave write strobe
opAvalon_Read  out  1  slave read strobe
ipAvalon_ReadData  in  Width  slave read data
ipAvalon_ReadValid  in  1  slave read-data valid
opError  out  1  sticky: ReadValid arrived with the response FIFO empty

Behaviour:
- Reset (async, all outputs): opMaster_WaitRequest all 1; opAvalon_Read=0; opAvalon_Write=0; opMaster_ReadValid=0; opError=0; FIFO empty; state IDLE; last-winner pointer = Masters-1.
- FSM states: IDLE, GRANT, WBURST.
- IDLE: with any Read|Write request, pick the first requester searching cyclically from last-winner+1. Register grant id and last-winner, then go to GRANT. One cycle of arbitration latency.
- GRANT: the command fields of the granted master drive the Avalon bus combinationally.
  - opMaster_WaitRequest[g] = ipAvalon_WaitRequest, or 1 when blocked. All other masters see 1.
- GRANT, read: opAvalon_Read = ipMaster_Read[g] and FIFO not full.
  - If the FIFO is full, the read is masked and WaitRequest[g]=1.
  - On acceptance (Read & !WaitRequest), push {g, BurstCount} into the FIFO and return to IDLE.
- GRANT, write: on the first accepted beat, latch BurstCount and set beat counter=1.
  - If BurstCount<=1, return to IDLE; otherwise go to WBURST.
- WBURST: the grant is held and the other masters stay waiting.
  - The counter increments per accepted beat; at counter==latched count, return to IDLE.
  - Gaps (Write low) within the burst are allowed.
- BurstCount value 0 is treated as 1.
- Read return path:
  - Each ipAvalon_ReadValid beat asserts opMaster_ReadValid[head id] combinationally; opMaster_ReadData = ipAvalon_ReadData.
  - The head beat counter decrements per beat; the FIFO pops on the last beat.
- Push and pop in the same cycle are legal; occupancy is unchanged, and a full FIFO accepts a push when it pops that cycle.
- ReadValid with the FIFO empty: beat dropped, opError set until reset.
- Reads and writes from different masters may overlap: a write burst may run while earlier reads are still returning.
- Reset mid-burst: all state is cleared immediately; in-flight responses are lost.

Optional Feature:
AVALON_ARBITER_FIXED_PRIORITY_EN:
- Defined: the lowest-index requesting master always wins in IDLE, and the last-winner pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released with no requests -> all WaitRequest=1, Avalon Read/Write=0, opError=0.
- Masters 0..3 all request single writes every cycle (BurstCount=1, slave WaitRequest=0) -> grants in order 0,1,2,3,0; each write on the bus 2 cycles after the previous one; with FIXED_PRIORITY_EN, master 0 wins every time.
- Master 1 writes a 4-beat burst while master 2 requests -> master 2 WaitRequest=1 until the 4th beat of master 1 is accepted; master 2 is granted the following cycle.
- Master 0 reads burst 3, then master 3 reads burst 2; slave returns 5 ReadValid beats -> opMaster_ReadValid=0001 for 3 beats, then 1000 for 2; FIFO empty afterwards.
- ResponseDepth=2; three reads issued, slave returns nothing -> third read masked, requester WaitRequest=1; after one full burst returns, the third read is accepted the same cycle as the pop.
- ReadValid pulse with no reads outstanding -> no opMaster_ReadValid asserted, opError=1 and sticky until ipReset.
